// File: rtl/t02_imu_spi_target.sv
// t02_imu_spi_target: SPI mode-0 IMU register-file target with coherent sensor snapshot.
module t02_imu_spi_target #(
  parameter logic [7:0] WHO_AM_I_VAL = 8'hEA,
  parameter int         SYNC_STAGES  = 2
) (
  input  logic        hz100,
  input  logic        rst,
  input  logic        sclk,
  input  logic        cs,
  input  logic        sdi,
  output logic        sdo,
  output logic        sdo_oe,
  input  logic [95:0] sensor_data,
  input  logic        sample_load,
  output logic [1:0]  reg_bank,
  output logic [7:0]  pwr_mgmt_1,
  output logic [7:0]  pwr_mgmt_2,
  output logic [7:0]  gyro_cfg,
  output logic [7:0]  accel_cfg,
  output logic        wr_strobe,
  output logic        xfer_done
);
  localparam logic [1:0] IDLE = 2'd0, CMD = 2'd1, WRITE = 2'd2, READ = 2'd3;
  logic [SYNC_STAGES-1:0] sclk_q, cs_q, sdi_q;
  logic sclk_d, cs_d, sclk_s, cs_s, sdi_s;
  logic sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic [1:0] state;
  logic [2:0] cnt;
  logic [6:0] addr, rd_addr, snap_idx;
  logic [7:0] sh, nb, rd_data, snap_b;
  logic first, commit, bank0, bank2;
  logic [95:0] snapshot, pending;
  logic pend_v;
  assign sclk_s = sclk_q[SYNC_STAGES-1];
  assign cs_s = cs_q[SYNC_STAGES-1];
  assign sdi_s = sdi_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign cs_rise = cs_s & ~cs_d;
  assign cs_fall = ~cs_s & cs_d;
  assign nb = {sh[6:0], sdi_s};
  assign bank0 = reg_bank == 2'd0;
  assign bank2 = reg_bank == 2'd2;
  assign sdo = (state == READ) ? sh[7] : 1'b0;
  assign sdo_oe = ~cs_s & (state == READ);
  assign commit = (state == WRITE) & sclk_rise & (cnt == 3'd7) & ~cs_rise;
  // CMD reads the address being decoded; READ prefetches the next burst byte
  assign rd_addr = (state == CMD) ? nb[6:0] : addr + 7'd1;
  assign snap_idx = rd_addr - 7'h2D;
  always_comb begin
    snap_b = 8'h00;
    for (int i = 0; i < 12; i++)
      if (snap_idx == 7'(i)) snap_b = snapshot[95-8*i -: 8];
  end
  always_comb
    rd_data = (rd_addr == 7'h7F) ? {2'b00, reg_bank, 4'b0000}
            : (bank0 && rd_addr == 7'h00) ? WHO_AM_I_VAL
            : (bank0 && rd_addr == 7'h06) ? pwr_mgmt_1
            : (bank0 && rd_addr == 7'h07) ? pwr_mgmt_2
            : (bank0 && rd_addr >= 7'h2D && rd_addr <= 7'h38) ? snap_b
            : (bank2 && rd_addr == 7'h01) ? gyro_cfg
            : (bank2 && rd_addr == 7'h14) ? accel_cfg
            : 8'h00;
  always_ff @(posedge hz100) begin
    if (rst) begin
      sclk_q <= '0;
      cs_q <= '1;
      sdi_q <= '0;
      sclk_d <= 1'b0;
      cs_d <= 1'b1;
    end else begin
      sclk_q <= {sclk_q[SYNC_STAGES-2:0], sclk};
      cs_q <= {cs_q[SYNC_STAGES-2:0], cs};
      sdi_q <= {sdi_q[SYNC_STAGES-2:0], sdi};
      sclk_d <= sclk_s;
      cs_d <= cs_s;
    end
  end
  always_ff @(posedge hz100) begin
    if (rst) begin
      state <= IDLE;
      cnt <= 3'd0;
      addr <= 7'd0;
      sh <= 8'h00;
      first <= 1'b0;
      wr_strobe <= 1'b0;
      xfer_done <= 1'b0;
    end else begin
      wr_strobe <= commit;
      xfer_done <= cs_rise;
      if (cs_rise) state <= IDLE;
      else case (state)
        IDLE: if (cs_fall) begin
          state <= CMD;
          cnt <= 3'd0;
        end
        CMD: if (sclk_rise) begin
          sh <= nb;
          cnt <= cnt + 3'd1;
          if (cnt == 3'd7) begin
            addr <= nb[6:0];
            state <= nb[7] ? READ : WRITE;
            first <= 1'b1;
            if (nb[7]) sh <= rd_data;
          end
        end
        WRITE: if (sclk_rise) begin
          sh <= nb;
          cnt <= cnt + 3'd1;
          if (cnt == 3'd7) addr <= addr + 7'd1;
        end
        READ: if (sclk_fall) begin
          // the first fall only presents the MSB already loaded at the command byte
          if (first) first <= 1'b0;
          else if (cnt == 3'd7) begin
            sh <= rd_data;
            addr <= addr + 7'd1;
            cnt <= 3'd0;
          end else begin
            sh <= {sh[6:0], 1'b0};
            cnt <= cnt + 3'd1;
          end
        end
      endcase
    end
  end
  always_ff @(posedge hz100) begin
    if (rst || (commit && bank0 && addr == 7'h06 && nb[7])) begin
      reg_bank <= 2'd0;
      pwr_mgmt_1 <= 8'h41;
      pwr_mgmt_2 <= 8'h00;
      gyro_cfg <= 8'h01;
      accel_cfg <= 8'h01;
    end else if (commit) begin
      if (addr == 7'h7F) reg_bank <= nb[5:4];
      else if (bank0 && addr == 7'h06) pwr_mgmt_1 <= nb;
      else if (bank0 && addr == 7'h07) pwr_mgmt_2 <= nb;
      else if (bank2 && addr == 7'h01) gyro_cfg <= nb;
      else if (bank2 && addr == 7'h14) accel_cfg <= nb;
    end
  end
  always_ff @(posedge hz100) begin
    if (rst) begin
      snapshot <= '0;
      pending <= '0;
      pend_v <= 1'b0;
    end else if (cs_rise) begin
      snapshot <= sample_load ? sensor_data : pend_v ? pending : snapshot;
      pend_v <= 1'b0;
    end else if (sample_load) begin
      if (cs_s) snapshot <= sensor_data;
      else begin
        pending <= sensor_data;
        pend_v <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_t02_imu_spi_target.sv
// tb_t02_imu_spi_target: scoreboard bench with a transaction-level register-map model.
module tb_t02_imu_spi_target;
  localparam int H = 6;
  logic hz100 = 0, rst = 1, sclk = 0, cs = 1, sdi = 0, sample_load = 0;
  logic [95:0] sensor_data = '0;
  logic sdo, sdo_oe, wr_strobe, xfer_done;
  logic [1:0] reg_bank;
  logic [7:0] pwr_mgmt_1, pwr_mgmt_2, gyro_cfg, accel_cfg;

  t02_imu_spi_target dut (
    .hz100(hz100), .rst(rst), .sclk(sclk), .cs(cs), .sdi(sdi), .sdo(sdo), .sdo_oe(sdo_oe),
    .sensor_data(sensor_data), .sample_load(sample_load), .reg_bank(reg_bank),
    .pwr_mgmt_1(pwr_mgmt_1), .pwr_mgmt_2(pwr_mgmt_2), .gyro_cfg(gyro_cfg),
    .accel_cfg(accel_cfg), .wr_strobe(wr_strobe), .xfer_done(xfer_done)
  );

  always #5 hz100 = ~hz100;

  int n_chk = 0, n_pass = 0, done_cnt = 0, exp_done = 0;
  logic [33:0] exp_wr[$];
  logic [7:0] exp_rd[$], got_rd[$];
  logic [7:0] wbuf[4];

  logic [1:0] m_bank;
  logic [7:0] m_p1, m_p2, m_g, m_a;
  logic [7:0] m_snap[12];
  logic [95:0] m_pend;
  bit m_pv;

  task automatic check(input string name, input logic [95:0] got, input logic [95:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic m_reset();
    m_bank = 0; m_p1 = 8'h41; m_p2 = 8'h00; m_g = 8'h01; m_a = 8'h01;
  endtask

  function automatic logic [33:0] m_cfg();
    return {m_bank, m_p1, m_p2, m_g, m_a};
  endfunction

  function automatic logic [7:0] m_rd(input logic [6:0] a);
    if (a == 7'h7F) return {2'b00, m_bank, 4'h0};
    if (m_bank == 0) begin
      if (a == 7'h00) return 8'hEA;
      if (a == 7'h06) return m_p1;
      if (a == 7'h07) return m_p2;
      if (a >= 7'h2D && a <= 7'h38) return m_snap[int'(a) - 45];
    end
    if (m_bank == 2) begin
      if (a == 7'h01) return m_g;
      if (a == 7'h14) return m_a;
    end
    return 8'h00;
  endfunction

  task automatic m_wr(input logic [6:0] a, input logic [7:0] d);
    if (a == 7'h7F) m_bank = d[5:4];
    else if (m_bank == 0 && a == 7'h06) begin
      if (d[7]) m_reset(); else m_p1 = d;
    end
    else if (m_bank == 0 && a == 7'h07) m_p2 = d;
    else if (m_bank == 2 && a == 7'h01) m_g = d;
    else if (m_bank == 2 && a == 7'h14) m_a = d;
  endtask

  task automatic m_load(input logic [95:0] d);
    for (int i = 0; i < 12; i++) m_snap[i] = d[95-8*i -: 8];
  endtask

  // monitor: pops expectations whenever the DUT strobes a write or a byte arrives
  always @(negedge hz100) if (!rst) begin
    if (xfer_done) done_cnt++;
    if (wr_strobe) begin
      check("wr_strobe_expected", exp_wr.size() > 0, 1);
      if (exp_wr.size() > 0)
        check("cfg_after_write", {reg_bank, pwr_mgmt_1, pwr_mgmt_2, gyro_cfg, accel_cfg}, exp_wr.pop_front());
    end
    while (got_rd.size() > 0) begin
      check("rd_expected", exp_rd.size() > 0, 1);
      if (exp_rd.size() > 0) check("rd_byte", got_rd.pop_front(), exp_rd.pop_front());
      else void'(got_rd.pop_front());
    end
  end

  task automatic bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
    rx = 0;
    for (int i = 0; i < n; i++) begin
      sdi = tx[7-i];
      repeat (H) @(negedge hz100);
      rx = {rx[6:0], sdo};
      sclk = 1;
      repeat (H) @(negedge hz100);
      sclk = 0;
    end
  endtask

  task automatic cs_low();
    cs = 0;
    repeat (H) @(negedge hz100);
  endtask

  task automatic cs_high();
    repeat (H) @(negedge hz100);
    cs = 1;
    exp_done++;
    if (m_pv) m_load(m_pend);
    m_pv = 0;
    repeat (8) @(negedge hz100);
    check("xfer_done_count", done_cnt, exp_done);
    check("sdo_idle", {sdo, sdo_oe}, 2'b00);
  endtask

  task automatic load_idle(input logic [95:0] d);
    sensor_data = d;
    sample_load = 1;
    @(negedge hz100);
    sample_load = 0;
    m_load(d);
    repeat (2) @(negedge hz100);
  endtask

  task automatic wr_xfer(input logic [6:0] a, input int n);
    logic [7:0] rx;
    logic [6:0] ma = a;
    cs_low();
    bits({1'b0, a}, 8, rx);
    for (int k = 0; k < n; k++) begin
      m_wr(ma, wbuf[k]);
      exp_wr.push_back(m_cfg());
      ma++;
      bits(wbuf[k], 8, rx);
    end
    cs_high();
  endtask

  task automatic rd_xfer(input logic [6:0] a, input int n, input int load_at, input logic [95:0] ld);
    logic [7:0] rx;
    for (int k = 0; k < n; k++) exp_rd.push_back(m_rd(a + 7'(k)));
    cs_low();
    bits({1'b1, a}, 8, rx);
    check("sdo_oe_read", sdo_oe, 1);
    for (int k = 0; k < n; k++) begin
      bits(8'h00, 8, rx);
      got_rd.push_back(rx);
      if (k == load_at) begin
        sensor_data = ld;
        sample_load = 1;
        @(negedge hz100);
        sample_load = 0;
        m_pend = ld;
        m_pv = 1;
      end
    end
    cs_high();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [7:0] rx;
    logic [6:0] addrs[10] = '{7'h00, 7'h06, 7'h07, 7'h2D, 7'h33, 7'h38, 7'h01, 7'h14, 7'h7F, 7'h7E};
    m_reset();
    m_load('0);
    m_pv = 0;
    repeat (2) @(negedge hz100);
    rst = 0;
    @(negedge hz100);
    check("rst_pwr1", pwr_mgmt_1, 8'h41);
    check("rst_pwr2", pwr_mgmt_2, 8'h00);
    check("rst_gyro", gyro_cfg, 8'h01);
    check("rst_accel", accel_cfg, 8'h01);
    check("rst_bank", reg_bank, 2'd0);
    check("rst_outs", {sdo, sdo_oe, wr_strobe, xfer_done}, 4'b0000);

    rd_xfer(7'h00, 1, -1, '0);

    wbuf[0] = 8'h20; wr_xfer(7'h7F, 1);
    wbuf[0] = 8'h03; wr_xfer(7'h01, 1);
    wbuf[0] = 8'h33; wr_xfer(7'h14, 1);
    check("bank_sel", reg_bank, 2'd2);
    check("gyro_wr", gyro_cfg, 8'h03);
    check("accel_wr", accel_cfg, 8'h33);
    wbuf[0] = 8'h00; wr_xfer(7'h7F, 1);
    check("bank_back", reg_bank, 2'd0);

    load_idle(96'h0102_0304_0506_0708_090A_0B0C);
    rd_xfer(7'h2D, 10, -1, '0);
    rd_xfer(7'h2D, 10, 3, {12{8'hFF}});
    rd_xfer(7'h2D, 12, -1, '0);

    wbuf[0] = 8'h5A; wr_xfer(7'h07, 1);
    cs_low();
    bits(8'h07, 8, rx);
    bits(8'hFF, 5, rx);
    cs_high();
    check("abort_pwr2", pwr_mgmt_2, 8'h5A);
    wbuf[0] = 8'h80; wr_xfer(7'h06, 1);
    check("devrst_pwr1", pwr_mgmt_1, 8'h41);
    check("devrst_pwr2", pwr_mgmt_2, 8'h00);
    rd_xfer(7'h06, 2, -1, '0);
    rd_xfer(7'h7E, 3, -1, '0);

    for (int it = 0; it < 40; it++) begin
      logic [6:0] a;
      int n;
      a = ($urandom_range(0, 4) == 0) ? 7'($urandom) : addrs[$urandom_range(0, 9)];
      n = $urandom_range(1, 3);
      case ($urandom_range(0, 2))
        0: load_idle({$urandom, $urandom, $urandom});
        1: begin
          for (int k = 0; k < 4; k++) wbuf[k] = 8'($urandom);
          if (a == 7'h7F && $urandom_range(0, 1) == 0) wbuf[0] = {2'b00, 2'($urandom_range(0, 1) * 2), 4'h0};
          wr_xfer(a, n);
        end
        default: rd_xfer(a, n + 1, $urandom_range(0, 1) ? $urandom_range(0, n) : -1, {$urandom, $urandom, $urandom});
      endcase
    end

    repeat (20) @(negedge hz100);
    check("rd_queue_drained", exp_rd.size(), 0);
    check("wr_queue_drained", exp_wr.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
